vga_pos_regs: RTL and testbench
===============================

# vga_pos_regs

CPU-facing register block that sits directly upstream of the VGA output stage. It captures memory-mapped writes of sprite coordinates (mx, my, p1x, p1y, p2x, p2y) and the control word (cont) into shadow registers. On CPU request it commits them atomically to the active registers at the next vertical-sync edge, so the VGA stage never sees a half-updated frame. It also provides register read-back, a frame counter and a frame-done pulse.

## Interface
- `ADDR_W`, 16, CPU address width
- `BASE`, 16'hFF00, window base; must be 8-aligned (low 3 bits zero)
- `clk` in 1: system clock (same clock that feeds the VGA stage)
- `reset` in 1: asynchronous, active-low reset
- `wr_en` in 1: CPU write strobe, one cycle per write
- `rd_en` in 1: CPU read strobe
- `addr` in ADDR_W: CPU address
- `wr_data` in 16: write data
- `rd_data` out 16: read data, registered
- `rd_valid` out 1: high one cycle when `rd_data` holds an in-window read
- `v_sync` in 1: vertical sync from the VGA stage, active-low pulse
- `mx`, `my`, `p1x`, `p1y`, `p2x`, `p2y`, `cont` out 16 each: active registers driving the VGA stage
- `frame_done` out 1: one-cycle pulse after each commit

## Operation
- Hit: `addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]`. Index `i = addr[2:0]`:
  - 0 mx, 1 my, 2 p1x, 3 p1y, 4 p2x, 5 p2y, 6 cont
  - 7 CTRL
- Write, index 0–6: updates the shadow register only. Active outputs are unchanged.
- Write, index 7, `wr_data[0]=1`: sets `pending`. A write with bit0=0 has no effect. Other bits are ignored.
- Read, index 0–6: returns the shadow value.
- Read, index 7: returns `{frame_cnt[7:0], 7'b0, pending}`.
- Non-hit read: `rd_data` = 0 and `rd_valid` = 0. Non-hit writes are ignored.
- `v_sync` passes through a 2-flop synchronizer followed by a falling-edge detector, producing `vs_fall`.
- State machine:
  - IDLE: waits for a CTRL write with bit0=1, then goes to PENDING.
  - PENDING: on `vs_fall`, goes to COMMIT.
  - COMMIT, one cycle:
    - active ← shadow for all 7 registers
    - `frame_cnt` increments, wrapping 8'hFF → 0
    - `frame_done` = 1 for this cycle
    - `pending` clears
    - next state IDLE
- `pending` = 1 in PENDING and COMMIT.
- Simultaneous events:
  - Shadow write in the same cycle as the COMMIT copy: active gets the pre-write shadow; the shadow takes the new value.
  - Request in the same cycle as `vs_fall` while IDLE: the request is registered, and the commit waits for the next `vs_fall`.
  - Request while PENDING or COMMIT: no effect; no queueing.
  - `vs_fall` while IDLE: no change.
- `rd_en` and `wr_en` together on the same index: the read returns the pre-write value.
- Reset, asynchronous and applicable mid-operation: the FSM goes to IDLE, all shadow and active registers go to 0, and `frame_cnt` = 0. A pending commit is discarded.

## Timing
- Reset values: all data outputs 0, `rd_data` 0, `rd_valid` 0, `frame_done` 0.
- Read latency: 1 cycle. `rd_data`/`rd_valid` appear in the cycle after `rd_en`, and `rd_valid` is high for one cycle.
- Write latency to shadow: visible to a read issued on the next cycle.
- Commit latency: the `v_sync` falling edge at the input is followed by COMMIT on the 3rd clk edge; the active outputs change on that edge.
- `frame_done` is coincident with the COMMIT cycle.
- All outputs are registered. There is no combinational path from `addr` or `wr_data` to any output.

## Configuration
- `VGA_REGS_CLAMP_EN` defined:
  - Writes to x indices (0, 2, 4) saturate to 639.
  - Writes to y indices (1, 3, 5) saturate to 479.
  - Values are treated as unsigned. `cont` is not clamped.
- Not defined: values are stored verbatim.

## Structure
- Shared package `vga_pkg`:
  - register index localparams: `IDX_MX` … `IDX_CONT`, `IDX_CTRL`
  - `H_ACTIVE`=640, `V_ACTIVE`=480
  - FSM state enum: `IDLE`, `PENDING`, `COMMIT`
- One sub-module: `vsync_edge`, containing the 2-flop synchronizer plus the registered falling-edge pulse.

## Test plan
- Reset, then read all 8 indices → every read returns 0; the CTRL read returns 0.
- Write `p1x`=100, `p1y`=200, no commit, then toggle `v_sync` twice → `p1x`/`p1y` outputs stay 0; a shadow read returns 100/200.
- Write `mx`=321, then CTRL=1, then `v_sync` falling edge → `mx`=321 three clks after the edge; `frame_done` is a one-cycle pulse; CTRL reads 16'h0100.
- Write `p2x`=5 in the same cycle as COMMIT with shadow `p2x`=7 → active `p2x`=7; the shadow reads 5.
- Assert `reset` low while PENDING → outputs clear immediately; a following `vs_fall` produces no `frame_done`.
- With `VGA_REGS_CLAMP_EN`: write `mx`=1000 and `my`=600 → shadow reads 639 and 479. Without it: reads 1000 and 600. Also run 256 commits → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared register indices, display limits and commit FSM states for the VGA position registers.
package vga_pkg;

    localparam logic [2:0] IDX_MX   = 3'd0;
    localparam logic [2:0] IDX_MY   = 3'd1;
    localparam logic [2:0] IDX_P1X  = 3'd2;
    localparam logic [2:0] IDX_P1Y  = 3'd3;
    localparam logic [2:0] IDX_P2X  = 3'd4;
    localparam logic [2:0] IDX_P2Y  = 3'd5;
    localparam logic [2:0] IDX_CONT = 3'd6;
    localparam logic [2:0] IDX_CTRL = 3'd7;

    localparam logic [15:0] H_ACTIVE = 16'd640;
    localparam logic [15:0] V_ACTIVE = 16'd480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Saturate x/y coordinates to the last visible pixel; cont passes through.
    function automatic logic [15:0] clamp_val(input logic [2:0] idx, input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if ((idx == IDX_MX || idx == IDX_P1X || idx == IDX_P2X) && v > H_ACTIVE - 16'd1)
            r = H_ACTIVE - 16'd1;
        else if ((idx == IDX_MY || idx == IDX_P1Y || idx == IDX_P2Y) && v > V_ACTIVE - 16'd1)
            r = V_ACTIVE - 16'd1;
        return r;
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Two-flop synchronizer for the active-low v_sync plus a registered one-cycle falling-edge pulse.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic v_sync_i,
    output logic vs_fall_o
);

    logic sync1_q, sync2_q, fall_q;

    // Flops reset high (sync idle level) so reset release never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= v_sync_i;
            sync2_q <= sync1_q;
            fall_q  <= sync2_q & ~sync1_q;
        end
    end

    assign vs_fall_o = fall_q;

endmodule

// File: rtl/vga_pos_regs.sv
// Shadow/active sprite position registers with atomic commit on v_sync falling edge.
// Build option: VGA_REGS_CLAMP_EN saturates x/y writes to the visible area.
//   state   | meaning
//   IDLE    | no commit requested
//   PENDING | commit requested, waiting for vs_fall
//   COMMIT  | active <= shadow happened on entry; frame_done high
module vga_pos_regs
    import vga_pkg::*;
#(
    parameter int unsigned        ADDR_W = 16,
    parameter logic [ADDR_W-1:0]  BASE   = 16'hFF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    input  logic              v_sync,
    output logic [15:0]       mx,
    output logic [15:0]       my,
    output logic [15:0]       p1x,
    output logic [15:0]       p1y,
    output logic [15:0]       p2x,
    output logic [15:0]       p2y,
    output logic [15:0]       cont,
    output logic              frame_done
);

    state_t      state_q, state_d;
    logic [15:0] shadow_q [7];
    logic [15:0] active_q [7];
    logic [7:0]  frame_cnt_q;
    logic        frame_done_q;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q;

    logic        vs_fall;
    logic        hit;
    logic [2:0]  idx;
    logic        wr_shadow;
    logic        req;
    logic        commit_go;
    logic        pending;
    logic [15:0] wr_val;

    vsync_edge u_vsync_edge (
        .clk       (clk),
        .reset     (reset),
        .v_sync_i  (v_sync),
        .vs_fall_o (vs_fall)
    );

    assign hit       = (addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
    assign idx       = addr[2:0];
    assign wr_shadow = wr_en && hit && (idx != IDX_CTRL);
    assign req       = wr_en && hit && (idx == IDX_CTRL) && wr_data[0];
    assign pending   = (state_q != IDLE);

`ifdef VGA_REGS_CLAMP_EN
    assign wr_val = clamp_val(idx, wr_data);
`else
    assign wr_val = wr_data;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)     state_d = PENDING;
            PENDING: if (vs_fall) state_d = COMMIT;
            COMMIT:               state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // The copy is tied to the edge that enters COMMIT so outputs change with it.
    assign commit_go = (state_q == PENDING) && (state_d == COMMIT);

    always_comb begin
        rd_data_d = 16'h0000;
        if (rd_en && hit) begin
            case (idx)
                IDX_MX:   rd_data_d = shadow_q[0];
                IDX_MY:   rd_data_d = shadow_q[1];
                IDX_P1X:  rd_data_d = shadow_q[2];
                IDX_P1Y:  rd_data_d = shadow_q[3];
                IDX_P2X:  rd_data_d = shadow_q[4];
                IDX_P2Y:  rd_data_d = shadow_q[5];
                IDX_CONT: rd_data_d = shadow_q[6];
                default:  rd_data_d = {frame_cnt_q, 7'b0, pending};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= 8'h00;
            frame_done_q <= 1'b0;
            rd_data_q    <= 16'h0000;
            rd_valid_q   <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                shadow_q[k] <= 16'h0000;
                active_q[k] <= 16'h0000;
            end
        end else begin
            state_q      <= state_d;
            frame_done_q <= commit_go;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_en && hit;
            if (commit_go)
                frame_cnt_q <= frame_cnt_q + 8'd1;
            for (int k = 0; k < 7; k++) begin
                if (wr_shadow && idx == 3'(k))
                    shadow_q[k] <= wr_val;
                if (commit_go)
                    active_q[k] <= shadow_q[k];
            end
        end
    end

    assign mx         = active_q[0];
    assign my         = active_q[1];
    assign p1x        = active_q[2];
    assign p1y        = active_q[3];
    assign p2x        = active_q[4];
    assign p2y        = active_q[5];
    assign cont       = active_q[6];
    assign frame_done = frame_done_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_vga_pos_regs.sv
// Randomized bench for vga_pos_regs against a register-level reference model.
module tb_vga_pos_regs;

    localparam logic [15:0] BASE_A = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wr_data = 16'h0;
    logic        v_sync = 1'b1;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] mx, my, p1x, p1y, p2x, p2y, cont;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_shadow [7];
    logic [15:0] m_active [7];
    int          m_cnt;
    bit          m_pend;

    vga_pos_regs #(.ADDR_W(16), .BASE(BASE_A)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .v_sync(v_sync),
        .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .cont(cont),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] act(input int i);
        case (i)
            0: return mx;
            1: return my;
            2: return p1x;
            3: return p1y;
            4: return p2x;
            5: return p2y;
            default: return cont;
        endcase
    endfunction

    function automatic logic [15:0] model_store(input int i, input logic [15:0] d);
`ifdef VGA_REGS_CLAMP_EN
        if ((i == 0 || i == 2 || i == 4) && d > 16'd639) return 16'd639;
        if ((i == 1 || i == 3 || i == 5) && d > 16'd479) return 16'd479;
`endif
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_shadow[i] = 16'h0;
            m_active[i] = 16'h0;
        end
        m_cnt  = 0;
        m_pend = 0;
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = BASE_A | 16'(idx); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (idx < 7) m_shadow[idx] = model_store(idx, d);
        else if (d[0]) m_pend = 1;
    endtask

    task automatic rd(input int idx, input string tag);
        logic [15:0] exp;
        @(negedge clk);
        rd_en = 1'b1; addr = BASE_A | 16'(idx);
        exp = (idx == 7) ? {8'(m_cnt % 256), 7'b0, m_pend} : m_shadow[idx];
        @(posedge clk); #1;
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    function automatic logic [15:0] miss_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a[15:3] == BASE_A[15:3]) a = a ^ 16'h8000;
        return a;
    endfunction

    task automatic rd_miss();
        @(negedge clk);
        rd_en = 1'b1; addr = miss_addr();
        @(posedge clk); #1;
        chk("miss_data", 32'(rd_data), 32'd0);
        chk("miss_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr_miss();
        @(negedge clk);
        wr_en = 1'b1; addr = miss_addr(); wr_data = 16'($urandom) | 16'h1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic restore_vsync();
        @(negedge clk);
        v_sync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Drive a v_sync fall and check the commit lands on the 3rd clock edge after it.
    task automatic commit(input bit full);
        int j;
        @(negedge clk);
        v_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        j = $urandom_range(0, 6);
        if (full) begin
            chk("fd_early", 32'(frame_done), 32'd0);
            chk("act_early", 32'(act(j)), 32'(m_active[j]));
        end
        @(posedge clk); #1;
        chk("fd_pulse", 32'(frame_done), 32'd1);
        for (int i = 0; i < 7; i++) m_active[i] = m_shadow[i];
        if (full)
            for (int i = 0; i < 7; i++) chk("act_commit", 32'(act(i)), 32'(m_active[i]));
        m_cnt++;
        m_pend = 0;
        @(posedge clk); #1;
        if (full) chk("fd_one_cycle", 32'(frame_done), 32'd0);
        restore_vsync();
    endtask

    initial begin
        int fd_seen;
        model_reset();
        #1;
        chk("rst_mx", 32'(mx), 32'd0);
        chk("rst_cont", 32'(cont), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) rd(i, "rst_read");

        // Shadow writes without a request never reach the outputs.
        wr(2, 16'd100);
        wr(3, 16'd200);
        repeat (2) begin
            @(negedge clk); v_sync = 1'b0;
            repeat (3) @(negedge clk);
            restore_vsync();
        end
        chk("p1x_held", 32'(p1x), 32'd0);
        chk("p1y_held", 32'(p1y), 32'd0);
        rd(2, "p1x_shadow");
        rd(3, "p1y_shadow");
        chk("p1x_const", 32'(m_shadow[2]), 32'd100);

        // Basic commit.
        wr(0, 16'd321);
        wr(7, 16'h0001);
        rd(7, "ctrl_pend");
        commit(1);
        chk("mx_321", 32'(mx), 32'd321);
        rd(7, "ctrl_after");

        // Shadow write accepted on the commit edge: active takes the old value.
        wr(4, 16'd7);
        wr(7, 16'h0001);
        @(negedge clk); v_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; addr = BASE_A | 16'd4; wr_data = 16'd5;
        @(posedge clk); #1;
        chk("race_fd", 32'(frame_done), 32'd1);
        chk("race_p2x", 32'(p2x), 32'd7);
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) m_active[i] = m_shadow[i];
        m_shadow[4] = 16'd5;
        m_cnt++;
        m_pend = 0;
        restore_vsync();
        rd(4, "race_shadow");

        // Request in the vs_fall cycle while IDLE waits for the next edge.
        wr(0, 16'd55);
        @(negedge clk); v_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; addr = BASE_A | 16'd7; wr_data = 16'h0001;
        @(negedge clk);
        wr_en = 1'b0;
        m_pend = 1;
        fd_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (frame_done) fd_seen++;
        end
        chk("req_vsfall_nofd", 32'(fd_seen), 32'd0);
        restore_vsync();
        rd(7, "req_vsfall_pend");
        wr(7, 16'h0001);
        commit(1);

        // CTRL write with bit0 clear does nothing.
        wr(7, 16'hFFFE);
        rd(7, "ctrl_bit0_clear");

        // Clamp behaviour.
        wr(0, 16'd1000);
        wr(1, 16'd600);
`ifdef VGA_REGS_CLAMP_EN
        chk("clamp_mx_model", 32'(m_shadow[0]), 32'd639);
`else
        chk("clamp_mx_model", 32'(m_shadow[0]), 32'd1000);
`endif
        rd(0, "clamp_mx");
        rd(1, "clamp_my");

        // Randomized mix against the model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: wr($urandom_range(0, 6), 16'($urandom));
                4, 5, 6:    rd($urandom_range(0, 7), "rand_rd");
                7:          rd_miss();
                8:          wr_miss();
                default: begin
                    wr(7, 16'($urandom));
                    if (m_pend) commit(1);
                end
            endcase
        end
        for (int i = 0; i < 8; i++) rd(i, "rand_final");

        // Reset while PENDING discards the request and clears outputs at once.
        wr(6, 16'hBEEF);
        wr(7, 16'h0001);
        commit(1);
        wr(7, 16'h0001);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_cont", 32'(cont), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); v_sync = 1'b0;
        fd_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (frame_done) fd_seen++;
        end
        chk("arst_no_commit", 32'(fd_seen), 32'd0);
        restore_vsync();
        rd(7, "arst_ctrl");
        rd(6, "arst_shadow");

        // 256 commits bring frame_cnt back to zero.
        for (int n = 0; n < 256; n++) begin
            wr(7, 16'h0001);
            commit(0);
        end
        rd(7, "cnt_wrap");
        chk("cnt_wrap_model", 32'(m_cnt % 256), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
